// File: rtl/qspi_flash_responder_if.sv
// qspi_flash_responder_if
//
// SPI pin bundle between a flash host (master) and the flash responder
// (slave). Pad splitting into a bidirectional DQ bus happens outside.
//
// Signals:
//   spi_csn    chip select, active low (host -> responder)
//   spi_sck    serial clock, SPI mode 0 (host -> responder)
//   spi_dq_i   DQ0..DQ3 values seen at the pads (host -> responder)
//   spi_dq_o   DQ0..DQ3 drive values (responder -> host)
//   spi_dq_oe  per-line output enable (responder -> host)
`timescale 1ns/1ps

interface qspi_flash_responder_if;
    logic       spi_csn;
    logic       spi_sck;
    logic [3:0] spi_dq_i;
    logic [3:0] spi_dq_o;
    logic [3:0] spi_dq_oe;

    modport master (
        output spi_csn,
        output spi_sck,
        output spi_dq_i,
        input  spi_dq_o,
        input  spi_dq_oe
    );

    modport slave (
        input  spi_csn,
        input  spi_sck,
        input  spi_dq_i,
        output spi_dq_o,
        output spi_dq_oe
    );
endinterface

// File: rtl/qspi_flash_responder.sv
// qspi_flash_responder
//
// Serial-NOR flash responder (N25Q-style command subset). The SPI pins are
// oversampled with clk (clk must be >= 8x SCK); commands are served from an
// internal 2^ADDR_W byte array that powers up erased (0xFF) and is not
// touched by reset.
//
// Supported opcodes: 0x03 READ, 0x0B FAST READ, 0x02 PAGE PROGRAM,
// 0x05 READ STATUS, 0x9F READ ID, 0x06 WREN, 0x04 WRDI.
// Optional feature macro: QSPI_QUAD_READ_EN adds 0x6B QUAD OUTPUT FAST READ.
//
// Ports:
//   clk    system clock
//   rst_n  synchronous active-low reset
//   spi    SPI pin bundle (slave modport)
//   busy   mirrors status WIP
`timescale 1ns/1ps

module qspi_flash_responder #(
    parameter int          ADDR_W      = 12,
    parameter logic [23:0] JEDEC_ID    = 24'h20BA18,
    parameter int          PROG_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    qspi_flash_responder_if.slave spi,
    output logic                  busy
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int PCW   = $clog2(PROG_CYCLES + 1);

    localparam logic [7:0] OP_READ  = 8'h03;
    localparam logic [7:0] OP_FREAD = 8'h0B;
    localparam logic [7:0] OP_PP    = 8'h02;
    localparam logic [7:0] OP_RDSR  = 8'h05;
    localparam logic [7:0] OP_RDID  = 8'h9F;
    localparam logic [7:0] OP_WREN  = 8'h06;
    localparam logic [7:0] OP_WRDI  = 8'h04;
`ifdef QSPI_QUAD_READ_EN
    localparam logic [7:0] OP_QREAD = 8'h6B;
`endif

    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_CMD     = 4'd1;
    localparam logic [3:0] S_ADDR    = 4'd2;
    localparam logic [3:0] S_DUMMY   = 4'd3;
    localparam logic [3:0] S_RD_DATA = 4'd4;
    localparam logic [3:0] S_WR_DATA = 4'd5;
    localparam logic [3:0] S_STAT    = 4'd6;
    localparam logic [3:0] S_ID      = 4'd7;
    localparam logic [3:0] S_IGNORE  = 4'd8;

    logic              csn_s1, csn_s2;
    logic              sck_s1, sck_s2, sck_q;
    logic [3:0]        dq_s1, dq_s2;
    logic              sck_rise, sck_fall;
    logic [7:0]        rx_byte;

    logic [3:0]        state;
    logic [4:0]        bit_cnt;
    logic [2:0]        out_cnt;
    logic [7:0]        shift_in;
    logic [7:0]        out_sr;
    logic [7:0]        opcode;
    logic [7:0]        load_byte;
    logic [ADDR_W-1:0] addr;
    logic [1:0]        id_idx;
    logic              got_byte;
    logic              pend_wren, pend_wrdi;
    logic              wel, wip;
    logic [PCW-1:0]    prog_cnt;
    logic [3:0]        dq_o_r;
    logic              oe_single;
`ifdef QSPI_QUAD_READ_EN
    logic              oe_quad;
`endif
    logic              mem_we;
    logic              unused_dq_hi;

    // Erased at configuration; deliberately outside the reset domain.
    logic [7:0]        mem [0:DEPTH-1] = '{default: 8'hFF};

    assign sck_rise = sck_s2 & ~sck_q;
    assign sck_fall = ~sck_s2 & sck_q;
    assign rx_byte  = {shift_in[6:0], dq_s2[0]};

    // Upper DQ lines are synchronised for symmetry, but this responder only
    // ever receives on DQ0.
    assign unused_dq_hi = ^dq_s2[3:1];

    // A byte commits only on its 8th rising edge, and never in the cycle
    // where chip select has already gone high.
    assign mem_we = rst_n && !csn_s2 && (state == S_WR_DATA) &&
                    sck_rise && (bit_cnt == 5'd7);

    // Byte presented at the start of each outgoing byte.
    always_comb begin
        load_byte = 8'h00;
        case (state)
            S_RD_DATA: load_byte = mem[addr];
            S_STAT:    load_byte = {6'b000000, wel, wip};
            S_ID: begin
                case (id_idx)
                    2'd0:    load_byte = JEDEC_ID[23:16];
                    2'd1:    load_byte = JEDEC_ID[15:8];
                    2'd2:    load_byte = JEDEC_ID[7:0];
                    default: load_byte = 8'h00;
                endcase
            end
            default:   load_byte = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[addr] <= mem[addr] & rx_byte;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            csn_s1    <= 1'b1;
            csn_s2    <= 1'b1;
            sck_s1    <= 1'b0;
            sck_s2    <= 1'b0;
            sck_q     <= 1'b0;
            dq_s1     <= 4'h0;
            dq_s2     <= 4'h0;
            state     <= S_IDLE;
            bit_cnt   <= 5'd0;
            out_cnt   <= 3'd0;
            shift_in  <= 8'h00;
            out_sr    <= 8'h00;
            opcode    <= 8'h00;
            addr      <= '0;
            id_idx    <= 2'd0;
            got_byte  <= 1'b0;
            pend_wren <= 1'b0;
            pend_wrdi <= 1'b0;
            wel       <= 1'b0;
            wip       <= 1'b0;
            prog_cnt  <= '0;
            dq_o_r    <= 4'h0;
            oe_single <= 1'b0;
`ifdef QSPI_QUAD_READ_EN
            oe_quad   <= 1'b0;
`endif
        end else begin
            csn_s1 <= spi.spi_csn;
            csn_s2 <= csn_s1;
            sck_s1 <= spi.spi_sck;
            sck_s2 <= sck_s1;
            sck_q  <= sck_s2;
            dq_s1  <= spi.spi_dq_i;
            dq_s2  <= dq_s1;

            // Program timer; a program can only start while WIP is clear,
            // so this never collides with the commit below.
            if (wip) begin
                if (prog_cnt == PCW'(1)) begin
                    wip <= 1'b0;
                end
                prog_cnt <= prog_cnt - PCW'(1);
            end

            if (csn_s2) begin
                // First cycle with csn high after a frame is the commit point
                // for WREN/WRDI and for a page program with full bytes.
                if (state != S_IDLE) begin
                    if (pend_wren) begin
                        wel <= 1'b1;
                    end
                    if (pend_wrdi) begin
                        wel <= 1'b0;
                    end
                    if (state == S_WR_DATA && got_byte) begin
                        wip      <= 1'b1;
                        wel      <= 1'b0;
                        prog_cnt <= PCW'(PROG_CYCLES);
                    end
                end
                state     <= S_IDLE;
                pend_wren <= 1'b0;
                pend_wrdi <= 1'b0;
                got_byte  <= 1'b0;
                dq_o_r    <= 4'h0;
                oe_single <= 1'b0;
`ifdef QSPI_QUAD_READ_EN
                oe_quad   <= 1'b0;
`endif
            end else begin
                case (state)
                    S_IDLE: begin
                        state   <= S_CMD;
                        bit_cnt <= 5'd0;
                        out_cnt <= 3'd0;
                        id_idx  <= 2'd0;
                    end

                    S_CMD: begin
                        if (sck_rise) begin
                            shift_in <= rx_byte;
                            if (bit_cnt == 5'd7) begin
                                bit_cnt <= 5'd0;
                                opcode  <= rx_byte;
                                if (wip && rx_byte != OP_RDSR) begin
                                    state <= S_IGNORE;
                                end else begin
                                    case (rx_byte)
                                        OP_READ:  state <= S_ADDR;
                                        OP_FREAD: state <= S_ADDR;
`ifdef QSPI_QUAD_READ_EN
                                        OP_QREAD: state <= S_ADDR;
`endif
                                        OP_PP:    state <= wel ? S_ADDR : S_IGNORE;
                                        OP_RDSR:  state <= S_STAT;
                                        OP_RDID:  state <= S_ID;
                                        OP_WREN: begin
                                            state     <= S_IGNORE;
                                            pend_wren <= 1'b1;
                                        end
                                        OP_WRDI: begin
                                            state     <= S_IGNORE;
                                            pend_wrdi <= 1'b1;
                                        end
                                        default:  state <= S_IGNORE;
                                    endcase
                                end
                            end else begin
                                bit_cnt <= bit_cnt + 5'd1;
                            end
                        end
                    end

                    S_ADDR: begin
                        // Upper flash address bits fall off the top: aliasing.
                        if (sck_rise) begin
                            addr <= {addr[ADDR_W-2:0], dq_s2[0]};
                            if (bit_cnt == 5'd23) begin
                                bit_cnt <= 5'd0;
                                if (opcode == OP_READ) begin
                                    state <= S_RD_DATA;
                                end else if (opcode == OP_PP) begin
                                    state <= S_WR_DATA;
                                end else begin
                                    state <= S_DUMMY;
                                end
                            end else begin
                                bit_cnt <= bit_cnt + 5'd1;
                            end
                        end
                    end

                    S_DUMMY: begin
                        if (sck_rise) begin
                            if (bit_cnt == 5'd7) begin
                                bit_cnt <= 5'd0;
                                state   <= S_RD_DATA;
                            end else begin
                                bit_cnt <= bit_cnt + 5'd1;
                            end
                        end
                    end

                    S_WR_DATA: begin
                        if (sck_rise) begin
                            shift_in <= rx_byte;
                            if (bit_cnt == 5'd7) begin
                                bit_cnt  <= 5'd0;
                                got_byte <= 1'b1;
                                addr     <= {addr[ADDR_W-1:8], addr[7:0] + 8'd1};
                            end else begin
                                bit_cnt <= bit_cnt + 5'd1;
                            end
                        end
                    end

                    S_RD_DATA, S_STAT, S_ID: begin
                        if (sck_fall) begin
                            out_cnt <= out_cnt + 3'd1;
`ifdef QSPI_QUAD_READ_EN
                            if (opcode == OP_QREAD) begin
                                oe_quad <= 1'b1;
                                if (out_cnt[0] == 1'b0) begin
                                    dq_o_r <= load_byte[7:4];
                                    out_sr <= {load_byte[3:0], 4'h0};
                                    addr   <= addr + ADDR_W'(1);
                                end else begin
                                    dq_o_r <= out_sr[7:4];
                                end
                            end else
`endif
                            begin
                                oe_single <= 1'b1;
                                if (out_cnt == 3'd0) begin
                                    dq_o_r <= {2'b00, load_byte[7], 1'b0};
                                    out_sr <= {load_byte[6:0], 1'b0};
                                    if (state == S_RD_DATA) begin
                                        addr <= addr + ADDR_W'(1);
                                    end
                                    if (state == S_ID && id_idx != 2'd3) begin
                                        id_idx <= id_idx + 2'd1;
                                    end
                                end else begin
                                    dq_o_r <= {2'b00, out_sr[7], 1'b0};
                                    out_sr <= {out_sr[6:0], 1'b0};
                                end
                            end
                        end
                    end

                    S_IGNORE: begin
                        // Anything past the 8th bit cancels a pending WREN/WRDI.
                        if (sck_rise) begin
                            pend_wren <= 1'b0;
                            pend_wrdi <= 1'b0;
                        end
                    end

                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    assign spi.spi_dq_o = dq_o_r;
`ifdef QSPI_QUAD_READ_EN
    assign spi.spi_dq_oe = {oe_quad, oe_quad, oe_quad | oe_single, oe_quad};
`else
    assign spi.spi_dq_oe = {2'b00, oe_single, 1'b0};
`endif
    assign busy = wip;

endmodule

// File: tb/tb_qspi_flash_responder.sv
// tb_qspi_flash_responder
//
// Scoreboard bench for qspi_flash_responder. Transaction tasks push the bytes
// the flash should return (from a byte-array model of the flash) into a
// queue; an independent monitor assembles bytes from the DQ lines whenever
// the responder drives them and compares against that queue.
`timescale 1ns/1ps

module tb_qspi_flash_responder;

    localparam int          CLK_P       = 10;
    localparam int          HALF        = 80;
    localparam int          ADDR_W      = 12;
    localparam int          DEPTH       = 1 << ADDR_W;
    localparam int          PROG_CYCLES = 400;
    localparam logic [23:0] JEDEC       = 24'h20BA18;

    logic clk = 1'b0;
    logic rst_n;
    logic busy;

    qspi_flash_responder_if spi_bus();

    qspi_flash_responder #(
        .ADDR_W      (ADDR_W),
        .JEDEC_ID    (JEDEC),
        .PROG_CYCLES (PROG_CYCLES)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .spi   (spi_bus),
        .busy  (busy)
    );

    always #(CLK_P/2) clk = ~clk;

    int         vectors_applied = 0;
    int         miscompares     = 0;
    logic [7:0] exp_q[$];
    logic [7:0] model_mem [DEPTH];
    logic       m_wel;
    logic       m_wip;
    time        prog_commit_time;

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        vectors_applied++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Monitor: collects bytes on DQ1 (single) or DQ3..0 (quad) at SCK rises.
    initial begin : monitor
        logic [7:0] acc;
        logic [7:0] exp_b;
        int         nbits;
        acc   = 8'h00;
        nbits = 0;
        forever begin
            @(posedge spi_bus.spi_sck or posedge spi_bus.spi_csn);
            if (spi_bus.spi_csn === 1'b1) begin
                nbits = 0;
            end else if (spi_bus.spi_dq_oe == 4'b0010) begin
                acc   = {acc[6:0], spi_bus.spi_dq_o[1]};
                nbits = nbits + 1;
            end else if (spi_bus.spi_dq_oe == 4'b1111) begin
                acc   = {acc[3:0], spi_bus.spi_dq_o};
                nbits = nbits + 4;
            end
            if (nbits >= 8) begin
                nbits = 0;
                if (exp_q.size() == 0) begin
                    vectors_applied++;
                    miscompares++;
                    $display("[TB] FAIL unexpected_byte: got 0x%0h, expected none", acc);
                end else begin
                    exp_b = exp_q.pop_front();
                    check_output("rx_byte", 32'(acc), 32'(exp_b));
                end
            end
        end
    end

    function automatic logic [7:0] model_status();
        return {6'b000000, m_wel, m_wip};
    endfunction

    task automatic spi_bit(input logic b);
        spi_bus.spi_dq_i = {3'b000, b};
        #(HALF);
        spi_bus.spi_sck = 1'b1;
        #(HALF);
        spi_bus.spi_sck = 1'b0;
    endtask

    task automatic spi_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) spi_bit(b[i]);
    endtask

    task automatic spi_clocks(input int n);
        for (int i = 0; i < n; i++) spi_bit(1'b0);
    endtask

    task automatic spi_end();
        #(2*CLK_P);
        spi_bus.spi_csn = 1'b1;
        #(8*CLK_P);
    endtask

    // Open a frame and send the opcode plus an optional 24-bit address.
    task automatic apply_stimulus(input logic [7:0] op, input logic with_addr,
                                  input logic [23:0] a);
        spi_bus.spi_csn = 1'b0;
        #(4*CLK_P);
        spi_byte(op);
        if (with_addr) begin
            spi_byte(a[23:16]);
            spi_byte(a[15:8]);
            spi_byte(a[7:0]);
        end
    endtask

    task automatic check_drain(input string name);
        check_output(name, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    task automatic do_read(input logic [7:0] op, input logic [23:0] a, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(model_mem[(int'(a) + i) % DEPTH]);
        apply_stimulus(op, 1'b1, a);
        if (op != 8'h03) spi_byte(8'h00);
        spi_clocks(n * ((op == 8'h6B) ? 2 : 8));
        spi_end();
        check_drain("read_drain");
    endtask

    task automatic do_status(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(model_status());
        apply_stimulus(8'h05, 1'b0, 24'h0);
        spi_clocks(8 * n);
        spi_end();
        check_drain("status_drain");
    endtask

    task automatic do_read_id(input int n);
        logic [7:0] id_bytes [3];
        id_bytes[0] = JEDEC[23:16];
        id_bytes[1] = JEDEC[15:8];
        id_bytes[2] = JEDEC[7:0];
        for (int i = 0; i < n; i++) exp_q.push_back((i < 3) ? id_bytes[i] : 8'h00);
        apply_stimulus(8'h9F, 1'b0, 24'h0);
        spi_clocks(8 * n);
        spi_end();
        check_drain("id_drain");
    endtask

    // WREN / WRDI with an optional number of surplus bits.
    task automatic do_simple(input logic [7:0] op, input int extra_bits);
        apply_stimulus(op, 1'b0, 24'h0);
        spi_clocks(extra_bits);
        spi_end();
        if (extra_bits == 0 && !m_wip) begin
            if (op == 8'h06) m_wel = 1'b1;
            if (op == 8'h04) m_wel = 1'b0;
        end
    endtask

    task automatic do_program(input logic [23:0] a, input logic [7:0] data[$],
                              input int extra_bits);
        logic accepted;
        int   page_base;
        accepted = m_wel && !m_wip;
        apply_stimulus(8'h02, 1'b1, a);
        foreach (data[i]) spi_byte(data[i]);
        for (int i = 0; i < extra_bits; i++) spi_bit(1'b0);
        #(2*CLK_P);
        spi_bus.spi_csn = 1'b1;
        prog_commit_time = $time;
        #(8*CLK_P);
        if (accepted && data.size() > 0) begin
            page_base = int'(a) % DEPTH - (int'(a) % 256);
            foreach (data[i])
                model_mem[page_base + (int'(a) + i) % 256] &= data[i];
            m_wip = 1'b1;
            m_wel = 1'b0;
        end
        check_output("busy_after_pp", 32'(busy), 32'(m_wip));
    endtask

    task automatic wait_ready();
        int n;
        int elapsed;
        n = 0;
        while (busy === 1'b1 && n < 4 * PROG_CYCLES) begin
            @(posedge clk);
            #1;
            n++;
        end
        elapsed = int'(($time - prog_commit_time) / CLK_P);
        check_output("wip_clears", 32'(busy), 32'd0);
        check_output("prog_time_in_window",
                     32'(elapsed >= PROG_CYCLES && elapsed <= PROG_CYCLES + 10), 32'd1);
        m_wip = 1'b0;
        @(posedge clk);
        #3;
    endtask

    initial begin : stimulus
        logic [7:0] data[$];
        logic [23:0] ra;
        int          choice;
        int          nb;

        for (int i = 0; i < DEPTH; i++) model_mem[i] = 8'hFF;
        m_wel = 1'b0;
        m_wip = 1'b0;
        prog_commit_time = 0;
        spi_bus.spi_csn  = 1'b1;
        spi_bus.spi_sck  = 1'b0;
        spi_bus.spi_dq_i = 4'h0;
        rst_n = 1'b0;

        // Reset
        repeat (3) @(posedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #3;
        check_output("reset_oe", 32'(spi_bus.spi_dq_oe), 32'h0);
        check_output("reset_dq_o", 32'(spi_bus.spi_dq_o), 32'h0);
        check_output("reset_busy", 32'(busy), 32'h0);
        do_status(1);

        // Identification
        do_read_id(4);

        // WREN only counts with exactly 8 bits
        do_simple(8'h06, 1);
        do_status(1);

        // Program with page wrap
        do_simple(8'h06, 0);
        do_status(2);
        data = '{8'hA5, 8'h3C, 8'h0F};
        do_program(24'h0000FE, data, 0);
        do_status(1);
        wait_ready();
        do_status(1);
        do_read(8'h03, 24'h0000FE, 2);
        do_read(8'h03, 24'h000000, 1);

        // AND semantics and discarded trailing bits
        do_simple(8'h06, 0);
        data = '{8'hFF};
        do_program(24'h0000FE, data, 4);
        wait_ready();
        do_read(8'h03, 24'h0000FE, 1);

        // Program without WREN is ignored
        data = '{8'h00};
        do_program(24'h0000FE, data, 0);
        do_status(1);
        do_read(8'h03, 24'h0000FE, 1);

        // WRDI clears WEL
        do_simple(8'h06, 0);
        do_simple(8'h04, 0);
        do_status(1);

        // Abort mid-read, then a clean READ ID
        apply_stimulus(8'h03, 1'b1, 24'h0000FE);
        spi_clocks(4);
        spi_end();
        check_output("oe_after_abort", 32'(spi_bus.spi_dq_oe), 32'h0);
        do_read_id(3);

        // Reset while a program is in progress
        do_simple(8'h06, 0);
        data = '{8'h5A};
        do_program(24'h000123, data, 0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_output("busy_after_reset", 32'(busy), 32'h0);
        check_output("oe_after_reset", 32'(spi_bus.spi_dq_oe), 32'h0);
        m_wip = 1'b0;
        m_wel = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #3;
        do_status(1);
        do_read(8'h03, 24'h000123, 1);

        // Reset while the responder is driving read data
        apply_stimulus(8'h03, 1'b1, 24'h000123);
        spi_clocks(3);
        #(4*CLK_P);
        check_output("oe_driving", 32'(spi_bus.spi_dq_oe), 32'h2);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_output("oe_reset_mid_read", 32'(spi_bus.spi_dq_oe), 32'h0);
        spi_bus.spi_csn = 1'b1;
        repeat (3) @(posedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #3;

        // FAST READ across the top of the array
        do_simple(8'h06, 0);
        data = '{8'h81};
        do_program(24'h000FFF, data, 0);
        wait_ready();
        do_read(8'h0B, 24'h000FFF, 2);
`ifdef QSPI_QUAD_READ_EN
        do_read(8'h6B, 24'h000FFF, 2);
`endif

        // Randomised traffic
        for (int it = 0; it < 10; it++) begin
            choice = int'($urandom_range(0, 3));
            ra     = 24'($urandom);
            nb     = int'($urandom_range(1, 3));
            case (choice)
                0: do_read(8'h03, ra, nb);
                1: begin
`ifdef QSPI_QUAD_READ_EN
                    if ($urandom_range(0, 1) == 1) do_read(8'h6B, ra, nb);
                    else
`endif
                    do_read(8'h0B, ra, nb);
                end
                2: begin
                    if ($urandom_range(0, 3) != 0) do_simple(8'h06, 0);
                    data.delete();
                    for (int k = 0; k < nb; k++) data.push_back(8'($urandom));
                    do_program(ra, data, int'($urandom_range(0, 3)));
                    if (m_wip) wait_ready();
                    do_read(8'h03, ra, nb);
                end
                default: do_status(1);
            endcase
        end

        check_output("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
        $finish;
    end

endmodule
